// File: rtl/link_pkg.sv
// Shared encodings and frame layout for the link_port serial status link.
// The frame layout depends on LINK_PARITY_EN (even parity bit after the data bits).
package link_pkg;

    typedef enum logic [2:0] {
        TIDLE,
        TSTART,
        TDATA,
        TPARITY,
        TSTOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RIDLE,
        RSTART,
        RDATA,
        RPARITY,
        RSTOP
    } rx_state_t;

    // Data-bit positions inside the three-bit status word.
    localparam int DATA_BITS   = 3;
    localparam int BIT_CONNECT = 0;
    localparam int BIT_START   = 1;
    localparam int BIT_FINISH  = 2;

    localparam logic [1:0] DATA_LAST = 2'(DATA_BITS - 1);

    // Frame bit indices on the wire, LSB first.
    localparam int IDX_START  = 0;
    localparam int IDX_DATA0  = 1;
`ifdef LINK_PARITY_EN
    localparam int IDX_PARITY = IDX_DATA0 + DATA_BITS;
    localparam int IDX_STOP   = IDX_PARITY + 1;
`else
    localparam int IDX_STOP   = IDX_DATA0 + DATA_BITS;
`endif
    localparam int FRAME_BITS = IDX_STOP + 1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/link_rx.sv
// Receive half of link_port: rx synchronizer, frame decoder and link timeout.
// Parity checking is present only when LINK_PARITY_EN is defined.
module link_rx
    import link_pkg::*;
#(
    parameter int BIT_CYCLES     = 868,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] receive_vec,
    output logic                 link_up,
    output logic                 frame_error
);

    localparam int BCW = $clog2(BIT_CYCLES);
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CYCLES - 1);
    localparam logic [BCW-1:0] BIT_HALF  = BCW'(BIT_CYCLES / 2);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES - 1);

    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t            rx_state_reg, rx_state_next;
    logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [1:0]           data_idx_reg, data_idx_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic [DATA_BITS-1:0] recv_reg, recv_next;
    logic                 link_reg, link_next;
    logic                 ferr_reg, ferr_next;
    logic [TOW-1:0]       to_cnt_reg, to_cnt_next;
`ifdef LINK_PARITY_EN
    logic                 par_reg, par_next;
`endif

    logic rx_fall, sample_point, bit_done, frame_ok, parity_ok;

    assign rx_fall      = rx_prev_reg & ~rx_sync_reg;
    assign sample_point = (bit_cnt_reg == BIT_HALF);
    assign bit_done     = (bit_cnt_reg == BIT_LAST);
`ifdef LINK_PARITY_EN
    assign parity_ok    = (par_reg == even_parity(data_reg));
`else
    assign parity_ok    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RIDLE;
            bit_cnt_reg  <= '0;
            data_idx_reg <= '0;
            data_reg     <= '0;
            recv_reg     <= '0;
            link_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            to_cnt_reg   <= '0;
`ifdef LINK_PARITY_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            bit_cnt_reg  <= bit_cnt_next;
            data_idx_reg <= data_idx_next;
            data_reg     <= data_next;
            recv_reg     <= recv_next;
            link_reg     <= link_next;
            ferr_reg     <= ferr_next;
            to_cnt_reg   <= to_cnt_next;
`ifdef LINK_PARITY_EN
            par_reg      <= par_next;
`endif
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        bit_cnt_next  = bit_cnt_reg;
        data_idx_next = data_idx_reg;
        data_next     = data_reg;
        ferr_next     = 1'b0;
        frame_ok      = 1'b0;
`ifdef LINK_PARITY_EN
        par_next      = par_reg;
`endif

        case (rx_state_reg)
            RIDLE: begin
                bit_cnt_next = '0;
                if (rx_fall) begin
                    rx_state_next = RSTART;
                end
            end
            RSTART: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
                // A start bit that is high again at mid-bit was only a glitch.
                if (sample_point && rx_sync_reg) begin
                    rx_state_next = RIDLE;
                    bit_cnt_next  = '0;
                end else if (bit_done) begin
                    rx_state_next = RDATA;
                    data_idx_next = '0;
                end
            end
            RDATA: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
                if (sample_point) begin
                    data_next[data_idx_reg] = rx_sync_reg;
                end
                if (bit_done) begin
                    if (data_idx_reg == DATA_LAST) begin
`ifdef LINK_PARITY_EN
                        rx_state_next = RPARITY;
`else
                        rx_state_next = RSTOP;
`endif
                    end else begin
                        data_idx_next = data_idx_reg + 1'b1;
                    end
                end
            end
            RPARITY: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
`ifdef LINK_PARITY_EN
                if (sample_point) begin
                    par_next = rx_sync_reg;
                end
`endif
                if (bit_done) begin
                    rx_state_next = RSTOP;
                end
            end
            RSTOP: begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
                // Decide at the stop sample and go idle at once so a back-to-back start edge is caught.
                if (sample_point) begin
                    rx_state_next = RIDLE;
                    bit_cnt_next  = '0;
                    if (rx_sync_reg && parity_ok) begin
                        frame_ok = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            default: begin
                rx_state_next = RIDLE;
                bit_cnt_next  = '0;
            end
        endcase
    end

    // A valid frame always wins over a timeout landing in the same cycle.
    always_comb begin
        recv_next   = recv_reg;
        link_next   = link_reg;
        to_cnt_next = to_cnt_reg;
        if (frame_ok) begin
            recv_next   = data_reg;
            link_next   = 1'b1;
            to_cnt_next = '0;
        end else if (to_cnt_reg == TO_LAST) begin
            recv_next   = '0;
            link_next   = 1'b0;
        end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    assign receive_vec = recv_reg;
    assign link_up     = link_reg;
    assign frame_error = ferr_reg;

endmodule

// File: rtl/link_port.sv
// Full-duplex status link: transmits local send_* levels and reports the peer's.
// Define LINK_PARITY_EN to add an even parity bit over the three data bits.
module link_port
    import link_pkg::*;
#(
    parameter int BIT_CYCLES       = 868,
    parameter int HEARTBEAT_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES   = 4000000
) (
    input  logic clk,
    input  logic reset,
    input  logic send_connect,
    input  logic send_start,
    input  logic send_game_finish,
    output logic tx,
    input  logic rx,
    output logic receive_connect,
    output logic receive_start,
    output logic receive_game_finish,
    output logic link_up,
    output logic frame_error
);

    localparam int BCW = $clog2(BIT_CYCLES);
    localparam int HBW = $clog2(HEARTBEAT_CYCLES);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);
    localparam logic [HBW-1:0] HB_LAST  = HBW'(HEARTBEAT_CYCLES - 1);

    tx_state_t            tx_state_reg, tx_state_next;
    logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [1:0]           data_idx_reg, data_idx_next;
    logic [DATA_BITS-1:0] snap_reg, snap_next;
    logic [HBW-1:0]       hb_cnt_reg, hb_cnt_next;
    logic                 tx_reg, tx_next;

    logic [DATA_BITS-1:0] send_vec;
    logic [DATA_BITS-1:0] receive_vec;
    logic                 bit_done, send_changed, launch;

    assign send_vec[BIT_CONNECT] = send_connect;
    assign send_vec[BIT_START]   = send_start;
    assign send_vec[BIT_FINISH]  = send_game_finish;

    assign bit_done     = (bit_cnt_reg == BIT_LAST);
    // snap_reg is both the frame being sent and the last value advertised.
    assign send_changed = (send_vec != snap_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TIDLE;
            bit_cnt_reg  <= '0;
            data_idx_reg <= '0;
            snap_reg     <= '0;
            hb_cnt_reg   <= '0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            bit_cnt_reg  <= bit_cnt_next;
            data_idx_reg <= data_idx_next;
            snap_reg     <= snap_next;
            hb_cnt_reg   <= hb_cnt_next;
            tx_reg       <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        bit_cnt_next  = bit_cnt_reg;
        data_idx_next = data_idx_reg;
        snap_next     = snap_reg;
        hb_cnt_next   = hb_cnt_reg;
        tx_next       = tx_reg;
        launch        = 1'b0;

        case (tx_state_reg)
            TIDLE: begin
                tx_next      = 1'b1;
                bit_cnt_next = '0;
                if (send_changed || (hb_cnt_reg == HB_LAST)) begin
                    launch = 1'b1;
                end else begin
                    hb_cnt_next = hb_cnt_reg + 1'b1;
                end
            end
            TSTART: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
                if (bit_done) begin
                    tx_state_next = TDATA;
                    data_idx_next = '0;
                    tx_next       = snap_reg[0];
                end
            end
            TDATA: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
                if (bit_done) begin
                    if (data_idx_reg == DATA_LAST) begin
`ifdef LINK_PARITY_EN
                        tx_state_next = TPARITY;
                        tx_next       = even_parity(snap_reg);
`else
                        tx_state_next = TSTOP;
                        tx_next       = 1'b1;
`endif
                    end else begin
                        data_idx_next = data_idx_reg + 1'b1;
                        tx_next       = snap_reg[data_idx_reg + 2'd1];
                    end
                end
            end
            TPARITY: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
                if (bit_done) begin
                    tx_state_next = TSTOP;
                    tx_next       = 1'b1;
                end
            end
            TSTOP: begin
                bit_cnt_next = bit_done ? '0 : bit_cnt_reg + 1'b1;
                // A change seen during the frame goes out back-to-back, skipping idle.
                if (bit_done) begin
                    if (send_changed) begin
                        launch = 1'b1;
                    end else begin
                        tx_state_next = TIDLE;
                    end
                end
            end
            default: begin
                tx_state_next = TIDLE;
                tx_next       = 1'b1;
            end
        endcase

        if (launch) begin
            tx_state_next = TSTART;
            tx_next       = 1'b0;
            snap_next     = send_vec;
            bit_cnt_next  = '0;
            hb_cnt_next   = '0;
        end
    end

    assign tx = tx_reg;

    link_rx #(
        .BIT_CYCLES     (BIT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .receive_vec (receive_vec),
        .link_up     (link_up),
        .frame_error (frame_error)
    );

    assign receive_connect     = receive_vec[BIT_CONNECT];
    assign receive_start       = receive_vec[BIT_START];
    assign receive_game_finish = receive_vec[BIT_FINISH];

endmodule

// File: tb/tb_link_port.sv
// Directed/randomized bench for link_port with tx optionally looped back to rx.
module tb_link_port;

    localparam int BC = 8;
    localparam int HB = 200;
    localparam int TO = 500;
`ifdef LINK_PARITY_EN
    localparam bit PAR_ON = 1'b1;
    localparam int NB     = 6;
`else
    localparam bit PAR_ON = 1'b0;
    localparam int NB     = 5;
`endif
    localparam int LAT = NB * BC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sc = 1'b0, ss = 1'b0, sg = 1'b0;
    logic rx_drv = 1'b1;
    logic loop = 1'b1;
    logic tx, rx;
    logic r_conn, r_start, r_fin, link_up, frame_error;
    logic [2:0] recv_vec;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    logic [2:0] exp_recv = 3'b000;
    logic       exp_link = 1'b0;

    assign rx       = loop ? tx : rx_drv;
    assign recv_vec = {r_fin, r_start, r_conn};

    link_port #(
        .BIT_CYCLES       (BC),
        .HEARTBEAT_CYCLES (HB),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .send_connect        (sc),
        .send_start          (ss),
        .send_game_finish    (sg),
        .tx                  (tx),
        .rx                  (rx),
        .receive_connect     (r_conn),
        .receive_start       (r_start),
        .receive_game_finish (r_fin),
        .link_up             (link_up),
        .frame_error         (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_send(input logic [2:0] v);
        {sg, ss, sc} = v;
    endtask

    // Expected wire level of frame bit k for status word d.
    function automatic logic frame_bit(input logic [2:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 3) return d[k-1];
        if (PAR_ON && k == 4) return ^d;
        return 1'b1;
    endfunction

    task automatic wait_fall(output int ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1);
            if (tx === 1'b0) begin
                ok = 1;
                return;
            end
        end
    endtask

    // Called just after tx went low; checks every bit mid-way and the looped-back result.
    task automatic watch_frame(input logic [2:0] d, input int chg_k, input logic [2:0] chg_v);
        int fe0;
        fe0 = fe_cnt;
        for (int k = 0; k < NB; k++) begin
            cyc(k == 0 ? 4 : BC);
            chk($sformatf("tx_bit%0d", k), tx, frame_bit(d, k));
            if (k == chg_k) set_send(chg_v);
        end
        cyc(3);
        chk("recv_before", recv_vec, exp_recv);
        chk("link_before", link_up, exp_link);
        cyc(1);
        exp_recv = d;
        exp_link = 1'b1;
        chk("recv_after", recv_vec, exp_recv);
        chk("link_after", link_up, exp_link);
        chk("frame_no_err", fe_cnt - fe0, 0);
        $display("frame d=%b recv=%b link=%b", d, recv_vec, link_up);
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        cyc(BC);
    endtask

    task automatic inject(input logic [2:0] d, input logic par, input logic stop);
        int   fe0;
        logic ok;
        fe0 = fe_cnt;
        drive_bit(1'b0);
        for (int k = 0; k < 3; k++) drive_bit(d[k]);
        if (PAR_ON) drive_bit(par);
        drive_bit(stop);
        rx_drv = 1'b1;
        cyc(2 * BC);
        ok = stop && (!PAR_ON || (par == ^d));
        if (ok) begin
            exp_recv = d;
            exp_link = 1'b1;
        end
        chk("inj_recv", recv_vec, exp_recv);
        chk("inj_link", link_up, exp_link);
        chk("inj_ferr", fe_cnt - fe0, ok ? 0 : 1);
        $display("inject d=%b par=%b stop=%b recv=%b ferr_pulses=%0d", d, par, stop, recv_vec, fe_cnt - fe0);
    endtask

    initial begin
        logic [2:0] d, cur;
        int ok, fe0;

        // Reset state
        reset = 1'b1;
        loop  = 1'b1;
        set_send(3'b000);
        cyc(5);
        chk("rst_tx", tx, 1'b1);
        chk("rst_recv", recv_vec, 3'b000);
        chk("rst_link", link_up, 1'b0);
        chk("rst_ferr", frame_error, 1'b0);

        // First frame starts on the first cycle after reset when a send is set
        set_send(3'b001);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("first_start", tx, 1'b0);
        watch_frame(3'b001, -1, 3'b000);
        cur = 3'b001;

        // Random status changes through the loopback
        for (int i = 0; i < 4; i++) begin
            do d = 3'($urandom_range(0, 7)); while (d == cur);
            set_send(d);
            wait_fall(ok);
            chk("loop_fall", ok, 1);
            watch_frame(d, -1, 3'b000);
            cur = d;
        end

        // Change during TDATA of a connect-only frame gives a back-to-back frame
        if (cur == 3'b001) begin
            set_send(3'b100);
            wait_fall(ok);
            chk("pre_fall", ok, 1);
            watch_frame(3'b100, -1, 3'b000);
        end
        set_send(3'b001);
        wait_fall(ok);
        chk("b2b_first_fall", ok, 1);
        watch_frame(3'b001, 1, 3'b011);
        chk("b2b_start", tx, 1'b0);
        watch_frame(3'b011, -1, 3'b000);
        cur = 3'b011;

        // Heartbeat after HB idle cycles
        cyc(HB - 1);
        chk("hb_not_yet", tx, 1'b1);
        cyc(1);
        chk("hb_start", tx, 1'b0);
        watch_frame(3'b011, -1, 3'b000);

        // Break loopback: link times out TO cycles after the last frame
        loop   = 1'b0;
        rx_drv = 1'b1;
        cyc(TO - 1);
        chk("to_link_hold", link_up, 1'b1);
        chk("to_recv_hold", recv_vec, 3'b011);
        cyc(1);
        exp_recv = 3'b000;
        exp_link = 1'b0;
        chk("to_link_down", link_up, exp_link);
        chk("to_recv_clear", recv_vec, exp_recv);

        // Injected frames: good, bad parity, bad stop, random
        d = 3'($urandom_range(1, 7));
        inject(d, ^d, 1'b1);
        inject(3'b001, 1'b0, 1'b1);
        d = 3'($urandom_range(0, 7));
        inject(d, ^d, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = 3'($urandom_range(0, 7));
            inject(d, (^d) ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 3) != 0);
        end

        // Two-cycle glitch is ignored
        fe0 = fe_cnt;
        rx_drv = 1'b0;
        cyc(2);
        rx_drv = 1'b1;
        cyc(3 * BC);
        chk("glitch_ferr", fe_cnt - fe0, 0);
        chk("glitch_recv", recv_vec, exp_recv);
        chk("glitch_link", link_up, exp_link);
        $display("glitch recv=%b link=%b", recv_vec, link_up);

        // Let any heartbeat finish, then reset in the middle of TDATA
        wait_fall(ok);
        chk("hb_fall_found", ok, 1);
        cyc(LAT + 2);
        loop = 1'b1;
        do d = 3'($urandom_range(1, 7)); while (d == cur);
        set_send(d);
        wait_fall(ok);
        chk("mid_fall", ok, 1);
        cyc(12);
        reset = 1'b1;
        cyc(1);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_recv", recv_vec, 3'b000);
        chk("midrst_link", link_up, 1'b0);
        chk("midrst_ferr", frame_error, 1'b0);
        cyc(2);
        exp_recv = 3'b000;
        exp_link = 1'b0;
        reset = 1'b0;
        cyc(1);
        chk("postrst_start", tx, 1'b0);
        watch_frame(d, -1, 3'b000);

        // With nothing to send, the first frame waits for the heartbeat
        reset = 1'b1;
        set_send(3'b000);
        cyc(3);
        reset = 1'b0;
        exp_recv = 3'b000;
        exp_link = 1'b0;
        cyc(HB - 1);
        chk("idle_hb_wait", tx, 1'b1);
        cyc(1);
        chk("idle_hb_start", tx, 1'b0);
        watch_frame(3'b000, -1, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
